// File: rtl/vga_pkg.sv
// Shared VGA timing, tile geometry and pixel types for the video pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // Visible area as produced by vga_control
    localparam int H_TDISP   = 640;
    localparam int V_TDISP   = 480;

    // Tile geometry: 16x16 pixel tiles, 40 x 30 tiles on screen
    localparam int TILE_BITS = 4;
    localparam int MAP_COLS  = 40;
    localparam int MAP_ROWS  = 30;

    // Clock cycles from a count/sync change to the matching pixel/sync output
    localparam int PIPE_LAT  = 4;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb332_t;

    // Palette power-up contents: entry i reads back as {i, i}, a visible grey-ish ramp
    function automatic logic [7:0] pal_init(input int idx);
        logic [3:0] n;
        n = 4'(idx);
        return {n, n};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register for the {h_sync, v_sync, bright, h_count, v_count} bundle.
// Latency: N clock cycles, every stage advances on every edge.
// Backpressure: none; reset loads every stage with RST_VAL (per-bit reset pattern).
module vga_sync_delay #(
    parameter int          N       = 1,
    parameter int          W       = 23,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [N-1:0][W-1:0] r_stage;

    // Shift the bundle one stage per clock; reset parks every stage on its idle pattern
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= {N{RST_VAL}};
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[N-1];

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile renderer: map RAM -> pattern ROM -> 16-entry palette -> RGB332 pixel, sync realigned.
// Latency: 4 clk_50MHz cycles from a count/sync change to the matching pixel and sync.
// Backpressure: none; free-running pipeline, map/pattern memories must answer within one cycle.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int COUNTER_BITS  = 10,
    parameter int TILE_BITS     = vga_pkg::TILE_BITS,
    parameter int MAP_COLS      = vga_pkg::MAP_COLS,
    parameter int MAP_ROWS      = vga_pkg::MAP_ROWS,
    parameter int MAP_ADDR_BITS = 11,
    parameter int IDX_BITS      = 8,
    parameter int COLOR_BITS    = 4
) (
    input  logic                            clk_50MHz,
    input  logic                            clear,
    input  logic [COUNTER_BITS-1:0]         h_count_in,
    input  logic [COUNTER_BITS-1:0]         v_count_in,
    input  logic                            bright_in,
    input  logic                            h_sync_in,
    input  logic                            v_sync_in,
    output logic [MAP_ADDR_BITS-1:0]        map_addr,
    input  logic [IDX_BITS-1:0]             map_data,
    output logic [IDX_BITS+2*TILE_BITS-1:0] pat_addr,
    input  logic [COLOR_BITS-1:0]           pat_data,
    input  logic                            pal_we,
    input  logic [COLOR_BITS-1:0]           pal_waddr,
    input  logic [7:0]                      pal_wdata,
    output logic [2:0]                      red,
    output logic [2:0]                      green,
    output logic [1:0]                      blue,
    output logic                            h_sync_out,
    output logic                            v_sync_out,
    output logic                            blank_n,
    output logic                            frame_start
);

    // Bundle layout through the delay line: {h_sync, v_sync, bright, h_count, v_count}
    localparam int CB     = COUNTER_BITS;
    localparam int PIPE_W = 3 + 2 * CB;
    localparam int PAL_N  = 1 << COLOR_BITS;
    localparam int PAT_W  = IDX_BITS + 2 * TILE_BITS;
    localparam int HS_BIT = 2 * CB + 2;
    localparam int VS_BIT = 2 * CB + 1;
    localparam int BR_BIT = 2 * CB;

    // Idle pattern: syncs inactive (high), blanked, counts at zero
    localparam logic [PIPE_W-1:0] PIPE_RST = {3'b110, {(2 * CB){1'b0}}};

    // The row-base multiply is hard-wired as (row<<5)+(row<<3), i.e. exactly 40 columns
    if (MAP_COLS != 40) begin : g_cols_chk
        $error("vga_tile_renderer: row-base multiply assumes 40 tile columns");
    end
    if (MAP_ROWS * MAP_COLS > (1 << MAP_ADDR_BITS)) begin : g_addr_chk
        $error("vga_tile_renderer: map address too narrow for the tile map");
    end
    if (COLOR_BITS != 4) begin : g_pal_chk
        $error("vga_tile_renderer: palette reset pattern assumes 16 entries");
    end

    // ------------------------------------------------------------------
    // Sync / blank / count delay line, tapped after S0, S2 and S3
    // ------------------------------------------------------------------
    logic [PIPE_W-1:0] w_in_vec;
    logic [PIPE_W-1:0] w_s0_vec;
    logic [PIPE_W-1:0] w_s2_vec;
    logic [PIPE_W-1:0] w_s3_vec;

    assign w_in_vec = {h_sync_in, v_sync_in, bright_in, h_count_in, v_count_in};

    vga_sync_delay #(
        .N       (1),
        .W       (PIPE_W),
        .RST_VAL (PIPE_RST)
    ) u_dly_s0 (
        .i_clk   (clk_50MHz),
        .i_rst_n (clear),
        .i_dat   (w_in_vec),
        .o_dat   (w_s0_vec)
    );

    vga_sync_delay #(
        .N       (2),
        .W       (PIPE_W),
        .RST_VAL (PIPE_RST)
    ) u_dly_s12 (
        .i_clk   (clk_50MHz),
        .i_rst_n (clear),
        .i_dat   (w_s0_vec),
        .o_dat   (w_s2_vec)
    );

    vga_sync_delay #(
        .N       (1),
        .W       (PIPE_W),
        .RST_VAL (PIPE_RST)
    ) u_dly_s3 (
        .i_clk   (clk_50MHz),
        .i_rst_n (clear),
        .i_dat   (w_s2_vec),
        .o_dat   (w_s3_vec)
    );

    // ------------------------------------------------------------------
    // S0: tile-map address from the live counts
    // ------------------------------------------------------------------
    logic [MAP_ADDR_BITS-1:0] w_tile_row;
    logic [MAP_ADDR_BITS-1:0] w_tile_col;
    logic [MAP_ADDR_BITS-1:0] w_map_addr_calc;
    logic [MAP_ADDR_BITS-1:0] r_map_addr;

    assign w_tile_row      = MAP_ADDR_BITS'(v_count_in >> TILE_BITS);
    assign w_tile_col      = MAP_ADDR_BITS'(h_count_in >> TILE_BITS);
    assign w_map_addr_calc = (w_tile_row << 5) + (w_tile_row << 3) + w_tile_col;

    // Register the map address; outside the visible area park it on entry 0 so the
    // counts running into the porches never address past the end of the map
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            r_map_addr <= '0;
        end else begin
            r_map_addr <= bright_in ? w_map_addr_calc : '0;
        end
    end

    // ------------------------------------------------------------------
    // S1: pattern address = {tile index, pixel row in tile, pixel col in tile}
    // ------------------------------------------------------------------
    logic [PAT_W-1:0] r_pat_addr;

    // Combine the returned tile index with the S0-delayed pixel offsets
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            r_pat_addr <= '0;
        end else begin
            r_pat_addr <= {map_data,
                           w_s0_vec[TILE_BITS-1:0],
                           w_s0_vec[CB+TILE_BITS-1:CB]};
        end
    end

    // ------------------------------------------------------------------
    // S2: capture the colour index from the pattern ROM
    // ------------------------------------------------------------------
    logic [COLOR_BITS-1:0] r_cidx;

    // Hold the pattern ROM answer for the palette lookup
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            r_cidx <= '0;
        end else begin
            r_cidx <= pat_data;
        end
    end

    // ------------------------------------------------------------------
    // Palette: 16 x RGB332, CPU-writable at any time
    // ------------------------------------------------------------------
    logic [7:0] r_pal [PAL_N];

    // Palette write port; a read on the same edge sees the pre-write entry
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_pal[i] <= pal_init(i);
            end
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    // ------------------------------------------------------------------
    // S3: palette lookup, blanking and frame-start detection
    // ------------------------------------------------------------------
    rgb332_t r_rgb;
    logic    r_frame_start;
    logic    w_s2_home;
    logic    w_s3_home;

    // Counts about to reach the output are (0,0), and the ones currently there are not
    assign w_s2_home = (w_s2_vec[2*CB-1:0] == '0);
    assign w_s3_home = (w_s3_vec[2*CB-1:0] == '0);

    // Pixel colour from the palette, forced black whenever the aligned bright is low
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_s2_vec[BR_BIT] ? rgb332_t'(r_pal[r_cidx]) : rgb332_t'(8'h00);
        end
    end

    // One-cycle pulse on the first output cycle of pixel (0,0)
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_s2_home && !w_s3_home;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign map_addr    = r_map_addr;
    assign pat_addr    = r_pat_addr;
    assign red         = r_rgb.red;
    assign green       = r_rgb.green;
    assign blue        = r_rgb.blue;
    assign h_sync_out  = w_s3_vec[HS_BIT];
    assign v_sync_out  = w_s3_vec[VS_BIT];
    assign blank_n     = w_s3_vec[BR_BIT];
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: history-based reference model plus directed literals.
// Latency: model predicts outputs from the inputs sampled PIPE_LAT-1 edges earlier.
// Backpressure: n/a; memories are modelled as one-cycle combinational lookups.
module tb_vga_tile_renderer;
    import vga_pkg::*;

    logic        clk_50MHz = 1'b0;
    logic        clear     = 1'b0;
    logic [9:0]  h_count_in = '0;
    logic [9:0]  v_count_in = '0;
    logic        bright_in  = 1'b0;
    logic        h_sync_in  = 1'b1;
    logic        v_sync_in  = 1'b1;
    logic [10:0] map_addr;
    logic [7:0]  map_data;
    logic [15:0] pat_addr;
    logic [3:0]  pat_data;
    logic        pal_we    = 1'b0;
    logic [3:0]  pal_waddr = '0;
    logic [7:0]  pal_wdata = '0;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        blank_n;
    logic        frame_start;

    always #10 clk_50MHz = ~clk_50MHz;

    vga_tile_renderer dut (
        .clk_50MHz   (clk_50MHz),
        .clear       (clear),
        .h_count_in  (h_count_in),
        .v_count_in  (v_count_in),
        .bright_in   (bright_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
        .pal_we      (pal_we),
        .pal_waddr   (pal_waddr),
        .pal_wdata   (pal_wdata),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .blank_n     (blank_n),
        .frame_start (frame_start)
    );

    // External memories: answer combinationally from the registered addresses
    logic [7:0] map_mem [2048];
    logic [3:0] pat_mem [65536];
    assign map_data = map_mem[map_addr];
    assign pat_data = pat_mem[pat_addr];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: history of sampled inputs, newest first
    // ------------------------------------------------------------------
    typedef struct {
        int h;
        int v;
        bit br;
        bit hs;
        bit vs;
    } ent_t;

    ent_t       hist [PIPE_LAT+1];
    logic [7:0] pal_m [16];

    logic [10:0] exp_map = '0;
    logic [15:0] exp_pat = '0;
    logic [7:0]  exp_rgb = '0;
    logic        exp_hs  = 1'b1;
    logic        exp_vs  = 1'b1;
    logic        exp_bl  = 1'b0;
    logic        exp_fs  = 1'b0;

    function automatic ent_t idle_ent();
        ent_t e;
        e.h = 0; e.v = 0; e.br = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
        return e;
    endfunction

    // Tile-map entry for a pixel: row-major 40-wide map, entry 0 outside the visible area
    function automatic int addr_of(input ent_t e);
        if (!e.br) return 0;
        return ((e.v / (1 << TILE_BITS)) * MAP_COLS + (e.h / (1 << TILE_BITS))) % 2048;
    endfunction

    function automatic int pat_of(input ent_t e);
        int tile;
        tile = int'(map_mem[addr_of(e)]);
        return tile * 256 + (e.v % 16) * 16 + (e.h % 16);
    endfunction

    function automatic bit at_home(input ent_t e);
        return (e.h == 0) && (e.v == 0);
    endfunction

    always @(posedge clk_50MHz) begin
        if (!clear) begin
            for (int i = 0; i <= PIPE_LAT; i++) hist[i] = idle_ent();
            for (int i = 0; i < 16; i++) pal_m[i] = 8'(i * 17);
            exp_map = '0;
            exp_pat = '0;
            exp_rgb = '0;
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_bl  = 1'b0;
            exp_fs  = 1'b0;
        end else begin
            for (int i = PIPE_LAT; i > 0; i--) hist[i] = hist[i-1];
            hist[0].h  = int'(h_count_in);
            hist[0].v  = int'(v_count_in);
            hist[0].br = bright_in;
            hist[0].hs = h_sync_in;
            hist[0].vs = v_sync_in;
            exp_map = 11'(addr_of(hist[0]));
            exp_pat = 16'(pat_of(hist[1]));
            exp_rgb = hist[PIPE_LAT-1].br ? pal_m[pat_mem[pat_of(hist[PIPE_LAT-1])]] : 8'h00;
            exp_hs  = hist[PIPE_LAT-1].hs;
            exp_vs  = hist[PIPE_LAT-1].vs;
            exp_bl  = hist[PIPE_LAT-1].br;
            exp_fs  = at_home(hist[PIPE_LAT-1]) && !at_home(hist[PIPE_LAT]);
            // Writes land after this edge's read
            if (pal_we) pal_m[pal_waddr] = pal_wdata;
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk_50MHz) begin
        if (chk_en) begin
            check("map_addr", 32'(map_addr), 32'(exp_map));
            check("pat_addr", 32'(pat_addr), 32'(exp_pat));
            check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
            check("h_sync_out", 32'(h_sync_out), 32'(exp_hs));
            check("v_sync_out", 32'(v_sync_out), 32'(exp_vs));
            check("blank_n", 32'(blank_n), 32'(exp_bl));
            check("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic set_in(input int h, input int v, input bit br, input bit hs, input bit vs);
        h_count_in = 10'(h);
        v_count_in = 10'(v);
        bright_in  = br;
        h_sync_in  = hs;
        v_sync_in  = vs;
    endtask

    task automatic rand_in();
        int h;
        int v;
        h = $urandom_range(0, 800);
        v = $urandom_range(0, 521);
        if ($urandom_range(0, 19) == 0) begin
            h = 0;
            v = 0;
        end
        set_in(h, v, (h < H_TDISP) && (v < V_TDISP),
               !(h >= 656 && h < 752) ^ ($urandom_range(0, 9) == 0),
               !(v >= 490 && v < 492) ^ ($urandom_range(0, 9) == 0));
    endtask

    task automatic rand_pal();
        pal_we    = ($urandom_range(0, 5) == 0);
        pal_waddr = 4'($urandom_range(0, 15));
        pal_wdata = 8'($urandom_range(0, 255));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) map_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 65536; i++) pat_mem[i] = 4'($urandom_range(0, 15));
        map_mem[122]      = 8'hA5;
        pat_mem[16'hA523] = 4'h7;
        pat_mem[16'hA524] = 4'h3;

        // Reset held with random inputs
        clear = 1'b0;
        @(posedge clk_50MHz);
        chk_en = 1'b1;
        repeat (4) begin
            @(negedge clk_50MHz); #1;
            rand_in();
        end
        check("rst_rgb", 32'({red, green, blue}), 32'h0);
        check("rst_hsync", 32'(h_sync_out), 32'h1);
        check("rst_vsync", 32'(v_sync_out), 32'h1);
        check("rst_blank_n", 32'(blank_n), 32'h0);

        @(negedge clk_50MHz); #1;
        clear = 1'b1;
        set_in(700, 500, 1'b0, 1'b1, 1'b1);
        pal_we = 1'b1; pal_waddr = 4'd7; pal_wdata = 8'hE0;
        @(negedge clk_50MHz); #1;
        pal_we = 1'b0;
        repeat (4) @(posedge clk_50MHz);

        // Addressing and pixel path: (35,50) -> tile (2,3) -> entry 122 -> A5 -> A523 -> idx 7
        @(negedge clk_50MHz); #1;
        set_in(35, 50, 1'b1, 1'b1, 1'b1);
        @(posedge clk_50MHz); #1;
        check("map_addr_122", 32'(map_addr), 32'd122);
        @(posedge clk_50MHz); #1;
        check("pat_addr_A523", 32'(pat_addr), 32'hA523);
        @(posedge clk_50MHz);
        @(posedge clk_50MHz); #1;
        check("pix_red", 32'(red), 32'd7);
        check("pix_green", 32'(green), 32'd0);
        check("pix_blue", 32'(blue), 32'd0);

        // Same counts, blanked
        @(negedge clk_50MHz); #1;
        set_in(35, 50, 1'b0, 1'b1, 1'b1);
        @(posedge clk_50MHz); #1;
        check("map_addr_blank", 32'(map_addr), 32'd0);
        repeat (3) @(posedge clk_50MHz);
        #1;
        check("rgb_blank", 32'({red, green, blue}), 32'h0);
        check("blank_n_low", 32'(blank_n), 32'h0);

        // hsync edge appears exactly 4 cycles after the input change
        @(negedge clk_50MHz); #1;
        set_in(100, 60, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk_50MHz);
        #1;
        check("hsync_lat3", 32'(h_sync_out), 32'h1);
        @(posedge clk_50MHz); #1;
        check("hsync_lat4", 32'(h_sync_out), 32'h0);

        // Last tile of the map and last pixel column/row inside it
        @(negedge clk_50MHz); #1;
        set_in(H_TDISP - 1, V_TDISP - 1, 1'b1, 1'b1, 1'b1);
        @(posedge clk_50MHz); #1;
        check("map_addr_last", 32'(map_addr), 32'(MAP_ROWS * MAP_COLS - 1));
        @(posedge clk_50MHz); #1;
        check("pat_addr_rowcol", 32'(pat_addr[7:0]), 32'hFF);

        // Palette collision: (36,50) -> A524 -> idx 3; write palette[3] on the read edge
        @(negedge clk_50MHz); #1;
        set_in(36, 50, 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk_50MHz);
        #1;
        pal_we = 1'b1; pal_waddr = 4'd3; pal_wdata = 8'h1C;
        @(posedge clk_50MHz); #1;
        pal_we = 1'b0;
        check("pal_old", 32'({red, green, blue}), 32'h33);
        @(posedge clk_50MHz); #1;
        check("pal_new", 32'({red, green, blue}), 32'h1C);

        // Frame wrap: (800,521) -> (0,0) -> (1,0)
        @(negedge clk_50MHz); #1;
        set_in(800, 521, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz); #1;
        set_in(0, 0, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz); #1;
        set_in(1, 0, 1'b1, 1'b1, 1'b1);
        @(posedge clk_50MHz); #1;
        check("fs_before", 32'(frame_start), 32'h0);
        @(posedge clk_50MHz); #1;
        check("fs_pulse", 32'(frame_start), 32'h1);
        @(posedge clk_50MHz); #1;
        check("fs_second", 32'(frame_start), 32'h0);

        // Random traffic, inputs held 2 cycles, with a mid-frame reset
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) begin
                @(negedge clk_50MHz); #1;
                clear = 1'b0;
                #1;
                check("midrst_rgb", 32'({red, green, blue}), 32'h0);
                check("midrst_hsync", 32'(h_sync_out), 32'h1);
                check("midrst_vsync", 32'(v_sync_out), 32'h1);
                check("midrst_blank_n", 32'(blank_n), 32'h0);
                check("midrst_map", 32'(map_addr), 32'h0);
                check("midrst_pat", 32'(pat_addr), 32'h0);
                repeat (3) @(negedge clk_50MHz);
                #1;
                clear = 1'b1;
            end
            @(negedge clk_50MHz); #1;
            rand_in();
            rand_pal();
            @(negedge clk_50MHz); #1;
            rand_pal();
        end
        @(negedge clk_50MHz); #1;
        pal_we = 1'b0;
        repeat (6) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
- Pixel-generation stage directly downstream of vga_control.
- Consumes h_count/v_count/bright/h_sync/v_sync and renders a 40x30 map of 16x16 tiles.
- Per pixel: map RAM lookup (tile index), then pattern ROM lookup (4-bit colour index), then a CPU-writable 16-entry palette, giving RGB332.
- Sync and blanking are delayed to match the fixed pipeline latency, so the monitor sees aligned signals.

Parameters:
- COUNTER_BITS, 10, width of incoming h/v counts.
- TILE_BITS, 4, log2 of tile edge in pixels (16x16 tiles).
- MAP_COLS, 40, tiles per row.
- MAP_ROWS, 30, tiles per column.
- MAP_ADDR_BITS, 11, map RAM address width (needs 1200 entries).
- IDX_BITS, 8, tile index width (256 patterns).
- COLOR_BITS, 4, palette index width (16 entries).

Ports:
- clk_50MHz  in  1  system clock; counts from vga_control change every 2 cycles.
- clear  in  1  asynchronous active-low reset.
- h_count_in  in  COUNTER_BITS  horizontal pixel count.
- v_count_in  in  COUNTER_BITS  vertical line count.
- bright_in  in  1  visible-area flag.
- h_sync_in  in  1  active-low hsync.
- v_sync_in  in  1  active-low vsync.
- map_addr  out  MAP_ADDR_BITS  tile-map RAM read address (registered).
- map_data  in  IDX_BITS  tile index; valid 1 cycle after map_addr.
- pat_addr  out  IDX_BITS+2*TILE_BITS  pattern ROM address, {idx, row[3:0], col[3:0]} (registered).
- pat_data  in  COLOR_BITS  colour index; valid 1 cycle after pat_addr.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  COLOR_BITS  palette entry to write.
- pal_wdata  in  8  RGB332 value.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.
- h_sync_out  out  1  delayed hsync.
- v_sync_out  out  1  delayed vsync.
- blank_n  out  1  delayed bright.
- frame_start  out  1  one-cycle pulse at the first output cycle of pixel (0,0).

Behaviour:
- Single clock domain. The pipeline advances every clk_50MHz edge with no enable. Inputs are held 2 cycles, so every output value is also held 2 cycles.
- S0: register the inputs. Compute map_addr = (v>>TILE_BITS)*MAP_COLS + (h>>TILE_BITS).
  - Force map_addr = 0 when bright_in = 0 (counts run past 639/479; never address out of range).
  - Multiply by constant 40 as (v<<5)+(v<<3), truncated to MAP_ADDR_BITS.
- S1: pat_addr <= {map_data, v[3:0], h[3:0]}, using the S0-delayed counts.
- S2: capture pat_data into a colour-index register.
- S3: {red, green, blue} <= palette[index] when the delayed bright = 1, else 8'h00.
- Latency: exactly 4 clk_50MHz cycles from any input change to the corresponding output. h_sync_out, v_sync_out and blank_n go through the same 4-stage delay.
- Palette: 16x8 register array.
  - Write takes effect on the clock edge where pal_we = 1.
  - If S3 reads the same entry on that same edge, it gets the old value.
  - Writes are allowed at any time, including the visible area.
- frame_start = 1 for exactly one cycle: the cycle where the delayed counts become (0,0) after differing from (0,0) on the previous cycle.
- Reset (clear = 0, async):
  - red/green/blue = 0, blank_n = 0, frame_start = 0.
  - h_sync_out = 1, v_sync_out = 1 (inactive); all sync delay stages = 1, bright stages = 0.
  - map_addr = 0, pat_addr = 0.
  - palette[i] = {i, i} (8 bits).
- Reset mid-frame: outputs go to reset values immediately. After release, the first 4 cycles emit blanked pixels with inactive sync, then track the inputs.
- Edge cases:
  - Tile (39,29) gives map_addr 1199.
  - h = 639 gives tile column 39, pixel column 15.
  - h/v at 640..800/480..521 are blanked regardless of memory data.

Decomposition:
- Package vga_pkg holds:
  - Timing constants shared with vga_control: H_TDISP 640, V_TDISP 480.
  - Tile constants: TILE_BITS, MAP_COLS, MAP_ROWS.
  - PIPE_LAT = 4.
  - Typedef rgb332_t.
- One sub-module: vga_sync_delay. It is a parameterised N-stage shift register of {h_sync, v_sync, bright, h_count, v_count} with per-bit reset values.

Test Plan:
- Reset: hold clear = 0 with random inputs → rgb = 0, h_sync_out = v_sync_out = 1, blank_n = 0. Release; outputs track the inputs at 4-cycle latency.
- Latency/alignment: drive h_sync_in low at cycle t → h_sync_out low at exactly t+4. blank_n equals bright_in delayed by 4.
- Addressing: h = 35, v = 50 → map_addr = 3*40+2 = 122. With map model returning 8'hA5 → pat_addr = 16'hA523.
- Pixel path: pattern model returns 4'h7, palette[7] written 8'hE0 → red = 7, green = 0, blue = 0, with bright = 1. Same stimulus with bright = 0 → rgb = 0, map_addr = 0.
- Palette collision: write palette[3] = 8'h1C on the same edge S3 reads index 3 → output is the old value 8'h33. The next read gives 8'h1C.
- Frame wrap: drive counts (800,521) → (0,0) → frame_start is a single 1-cycle pulse 4 cycles later. No pulse on the second cycle of (0,0).
